// File: rtl/warp_sched_pkg.sv
// Shared types and constants for the warp scheduler and its round-robin arbiter.
package warp_sched_pkg;

  localparam int unsigned NUM_WARPS        = 4;
  localparam int unsigned THREADS_PER_WARP = 8;
  localparam int unsigned NUM_THREADS      = NUM_WARPS * THREADS_PER_WARP;
  localparam int unsigned WARP_ID_W        = $clog2(NUM_WARPS);
  localparam int unsigned PC_WIDTH         = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSelect = 2'd1,
    StIssue  = 2'd2,
    StDone   = 2'd3
  } sched_state_e;

  typedef logic [WARP_ID_W-1:0] warp_id_t;

  // One bit per warp: set when none of the warp's threads is busy.
  function automatic logic [NUM_WARPS-1:0] warp_quiet(input logic [NUM_THREADS-1:0] threads);
    logic [NUM_WARPS-1:0] quiet;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      quiet[w] = ~|threads[w*THREADS_PER_WARP +: THREADS_PER_WARP];
    end
    return quiet;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester after rr_ptr.
module rr_arbiter
  import warp_sched_pkg::*;
(
  input  logic [NUM_WARPS-1:0] eligible,
  input  logic [WARP_ID_W-1:0] rr_ptr,
  output logic                 grant_valid,
  output logic [WARP_ID_W-1:0] grant_id
);

  warp_id_t idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      idx = WARP_ID_W'((32'(rr_ptr) + i) % NUM_WARPS);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp issue scheduler with per-warp PC/finished state and valid/ready issue port.
// Optional stall_cycles counter is built when WARP_SCHED_STALL_CNT_EN is defined.
module warp_scheduler
  import warp_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_WARPS-1:0]   warp_launch_mask,
  input  logic [PC_WIDTH-1:0]    start_pc,
  input  logic [NUM_THREADS-1:0] busy_threads,
  input  logic                   issue_ready,
  input  logic                   branch_en,
  input  logic [WARP_ID_W-1:0]   branch_warp,
  input  logic [PC_WIDTH-1:0]    branch_pc,
  input  logic                   halt_en,
  input  logic [WARP_ID_W-1:0]   halt_warp,
  output logic                   issue_valid,
  output logic [WARP_ID_W-1:0]   issue_warp,
  output logic [PC_WIDTH-1:0]    issue_pc,
  output logic                   busy,
  output logic                   done
`ifdef WARP_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  sched_state_e         state_q, state_d;
  logic [NUM_WARPS-1:0] launched_q, launched_d;
  logic [NUM_WARPS-1:0] finished_q, finished_d;
  logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
  logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
  warp_id_t             rr_ptr_q, rr_ptr_d;
  warp_id_t             issue_warp_q, issue_warp_d;
  logic [PC_WIDTH-1:0]  issue_pc_q, issue_pc_d;
  logic                 issue_valid_q, issue_valid_d;

  logic [NUM_WARPS-1:0] eligible;
  logic                 grant_valid;
  warp_id_t             grant_id;
  logic                 all_finished;
  logic                 running;
  logic                 load;
  logic                 handshake;

  // Any busy thread in a warp's slice stalls the whole warp.
  assign eligible     = launched_q & ~finished_q & warp_quiet(busy_threads);
  assign all_finished = ~|(launched_q & ~finished_q);
  assign running      = (state_q == StSelect) || (state_q == StIssue);
  assign load         = start && ((state_q == StIdle) || (state_q == StDone));
  assign handshake    = (state_q == StIssue) && issue_valid_q && issue_ready;

  rr_arbiter u_rr_arbiter (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d       = state_q;
    launched_d    = launched_q;
    finished_d    = finished_q;
    pc_d          = pc_q;
    rr_ptr_d      = rr_ptr_q;
    issue_warp_d  = issue_warp_q;
    issue_pc_d    = issue_pc_q;
    issue_valid_d = issue_valid_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (load) begin
          launched_d = warp_launch_mask;
          finished_d = '0;
          for (int unsigned w = 0; w < NUM_WARPS; w++) begin
            pc_d[w] = start_pc;
          end
          state_d = (warp_launch_mask == '0) ? StDone : StSelect;
        end
      end
      StSelect: begin
        if (all_finished) begin
          state_d = StDone;
        end else if (grant_valid) begin
          issue_warp_d  = grant_id;
          issue_pc_d    = pc_q[grant_id];
          issue_valid_d = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (handshake) begin
          pc_d[issue_warp_q] = pc_q[issue_warp_q] + 1'b1;
          rr_ptr_d           = issue_warp_q;
          issue_valid_d      = 1'b0;
          state_d            = StSelect;
        end
      end
    endcase

    // Applied after the handshake increment so a same-warp branch overrides it.
    if (running) begin
      if (branch_en) begin
        pc_d[branch_warp] = branch_pc;
      end
      if (halt_en) begin
        finished_d[halt_warp] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      launched_q    <= '0;
      finished_q    <= '0;
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        pc_q[w] <= '0;
      end
      rr_ptr_q      <= warp_id_t'(NUM_WARPS - 1);
      issue_warp_q  <= '0;
      issue_pc_q    <= '0;
      issue_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      launched_q    <= launched_d;
      finished_q    <= finished_d;
      pc_q          <= pc_d;
      rr_ptr_q      <= rr_ptr_d;
      issue_warp_q  <= issue_warp_d;
      issue_pc_q    <= issue_pc_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_pc    = issue_pc_q;
  assign busy        = running;
  assign done        = (state_q == StDone);

`ifdef WARP_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (load) begin
      stall_d = '0;
    end else if ((state_q == StSelect) && !grant_valid && !all_finished &&
                 (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/warp_scheduler.md
Name: warp_scheduler

Overview:
- Round-robin issue scheduler for the compute unit's 4 warps.
- Keeps a per-warp PC and finished flag.
- Each issue slot, it picks the next eligible warp: launched, not finished, and no thread in its 8-thread slice marked busy by the Scoreboard.
- It presents that warp and PC to fetch/decode with a valid/ready handshake, and raises done when every launched warp has halted.

Parameters:
- NUM_WARPS, 4, warps per compute unit (warp id width = 2)
- THREADS_PER_WARP, 8, threads per warp; busy slice width
- NUM_THREADS, 32, NUM_WARPS*THREADS_PER_WARP; width of busy_threads
- PC_WIDTH, 8, instruction address width

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begin scheduling launched warps
- warp_launch_mask  input  NUM_WARPS  warps participating in this kernel; sampled on start
- start_pc  input  PC_WIDTH  initial PC for all launched warps; sampled on start
- busy_threads  input  NUM_THREADS  Scoreboard busy vector; bits [8w+7:8w] belong to warp w
- issue_ready  input  1  fetch/decode accepts the issued warp this cycle
- branch_en  input  1  overwrite a warp's PC (from controller)
- branch_warp  input  2  warp id for branch_en
- branch_pc  input  PC_WIDTH  new PC for branch_warp
- halt_en  input  1  warp executed HALT
- halt_warp  input  2  warp id for halt_en
- issue_valid  output  1  issue_warp/issue_pc are valid
- issue_warp  output  2  selected warp id
- issue_pc  output  PC_WIDTH  PC of selected warp
- busy  output  1  scheduler running (not IDLE/DONE)
- done  output  1  all launched warps halted; held until next start or reset

Behaviour:
- Clock is clk. Reset is synchronous and active-high: reset is sampled only on the rising edge of clk.
- Reset values:
  - state=IDLE; all outputs 0.
  - pc[w]=0, finished[w]=0, launched[w]=0.
  - rr_ptr=NUM_WARPS-1, so warp 0 is checked first.
- Eligibility: eligible[w] = launched[w] & ~finished[w] & ~|busy_threads[8w+7:8w]. Conservative rule: any busy thread stalls the whole warp.
- Round-robin selection: search order rr_ptr+1, rr_ptr+2, ... modulo NUM_WARPS, wrapping 3->0; the first eligible warp wins.
- FSM states:
  - IDLE: on start, load launched=warp_launch_mask, pc[all]=start_pc, finished=0, go to SELECT. If warp_launch_mask==0, go directly to DONE.
  - SELECT: if any warp is eligible, register the winner into issue_warp/issue_pc, set issue_valid=1, go to ISSUE. Otherwise stay in SELECT (stall). If all launched warps are finished, go to DONE.
  - ISSUE: hold issue_valid, issue_warp and issue_pc stable until issue_ready. On issue_valid&issue_ready (handshake): pc[issue_warp]+=1 (wraps modulo 2^PC_WIDTH), rr_ptr=issue_warp, issue_valid=0, go to SELECT.
  - DONE: done=1, busy=0. Stay until start (same load as IDLE) or reset.
- Latency: minimum 2 cycles per issue (SELECT→ISSUE), i.e. one instruction per 2 clk with issue_ready tied high.
- busy_threads is evaluated only in SELECT. A warp that becomes busy while in ISSUE is still issued; the Scoreboard covers it after issue.
- Branch handling: branch_en writes pc[branch_warp]=branch_pc in any state except IDLE/DONE. If branch_en targets the same warp on the same cycle as an issue handshake, the branch wins and no increment is applied.
- Halt handling: halt_en sets finished[halt_warp]. If that warp is currently held in ISSUE, issue_valid stays asserted until the handshake (no retraction).
- halt_en/branch_en on an unlaunched warp are ignored for eligibility; the flag/PC is updated but has no effect.
- start while busy is ignored.
- Reset mid-operation returns every register to its reset value in one cycle; an in-flight issue is dropped.

Optional Feature:
- Macro WARP_SCHED_STALL_CNT_EN.
- Defined:
  - Extra output stall_cycles [15:0] counts cycles spent in SELECT with no eligible warp and not all finished.
  - The count saturates at 16'hFFFF and clears on start or reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package warp_sched_pkg:
  - state encoding (IDLE=2'd0, SELECT=2'd1, ISSUE=2'd2, DONE=2'd3)
  - NUM_WARPS and THREADS_PER_WARP constants
  - warp-id width constant
- One natural sub-module: rr_arbiter. Inputs are eligible[NUM_WARPS] and rr_ptr; outputs are grant_valid and grant_id. It is purely combinational and reusable by the LSU arbitration.

Test Plan:
- Basic round-robin: start with launch_mask=4'b1111, start_pc=8'h10, busy_threads=0, issue_ready=1 -> issues warps 0,1,2,3,0 with PCs 10,10,10,10,11, one issue every 2 cycles.
- Scoreboard stall: busy_threads=32'h0000_FF00 (warp 1 busy) -> warp 1 skipped (0,2,3,0...). Clear the busy bits -> warp 1 is issued on the next SELECT.
- Backpressure: issue_ready=0 for 5 cycles in ISSUE -> issue_valid, issue_warp and issue_pc stable for all 5 cycles; PC increments exactly once after ready.
- Branch collision: branch_en to warp 2 with branch_pc=8'h40 on warp 2's handshake cycle -> next issue of warp 2 has PC 8'h40, not 8'h41.
- Halt/done: launch_mask=4'b0101, halt warps 0 then 2 -> only warps 0 and 2 are ever issued; done=1 and busy=0 after the second halt; mask 0 -> done the cycle after start.
- Reset mid-ISSUE: assert reset while issue_valid=1 -> next cycle issue_valid=0, state IDLE, done=0, all PCs 0.
